// File: rtl/baud_generator_if.sv
// baud_generator_if: divisor programming, run control and strobe outputs of the baud generator
interface baud_generator_if;
  logic        enable;
  logic        load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        acq_sig;
  logic        baud_sig;
  logic        div_error;
  logic        running;
  modport master(
    output enable, load, div_int, div_frac,
    input  acq_sig, baud_sig, div_error, running
  );
  modport slave(
    input  enable, load, div_int, div_frac,
    output acq_sig, baud_sig, div_error, running
  );
endinterface

// File: rtl/baud_generator.sv
// baud_generator: fractional clock divider producing 16x-baud acquisition and 1x-baud bit strobes
module baud_generator #(
  parameter logic [15:0] RESET_DIV_INT  = 16'd27,
  parameter logic [3:0]  RESET_DIV_FRAC = 4'd2
) (
  input logic             clk,
  input logic             rst_n,
  baud_generator_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_nxt;
  logic [15:0] div_cnt, shadow_int, active_int, entry_int;
  logic [3:0]  frac_acc, sub_cnt, shadow_frac, active_frac, entry_frac;
  logic [16:0] period;
  logic [4:0]  frac_sum;
  logic        load_pending, div_error;
  logic        load_ok, start, stop, acq, baud, apply;
  always_comb begin
    state_nxt = bus.enable ? RUN : IDLE;
  end
  always_comb begin
    load_ok    = bus.load && (bus.div_int >= 16'd2);
    start      = (state == IDLE) && bus.enable;
    stop       = (state == RUN) && !bus.enable;
    acq        = (state == RUN) && bus.enable && ({1'b0, div_cnt} == period - 17'd1);
    baud       = acq && (sub_cnt == 4'hF);
    apply      = baud && load_pending;
    frac_sum   = {1'b0, frac_acc} + {1'b0, active_frac};
    entry_int  = load_ok ? bus.div_int  : shadow_int;
    entry_frac = load_ok ? bus.div_frac : shadow_frac;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      frac_acc     <= '0;
      sub_cnt      <= '0;
      period       <= {1'b0, RESET_DIV_INT};
      shadow_int   <= RESET_DIV_INT;
      shadow_frac  <= RESET_DIV_FRAC;
      active_int   <= RESET_DIV_INT;
      active_frac  <= RESET_DIV_FRAC;
      load_pending <= 1'b0;
      div_error    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_ok) begin
        shadow_int  <= bus.div_int;
        shadow_frac <= bus.div_frac;
        div_error   <= 1'b0;
      end else if (bus.load) begin
        div_error <= 1'b1;
      end
      // a load landing on a bit boundary stays pending for the next boundary
      load_pending <= start ? 1'b0 : (load_ok || (load_pending && !apply));
      if (start) begin
        active_int  <= entry_int;
        active_frac <= entry_frac;
        div_cnt     <= '0;
        frac_acc    <= '0;
        sub_cnt     <= '0;
        period      <= {1'b0, entry_int};
      end else if (stop) begin
        div_cnt  <= '0;
        frac_acc <= '0;
        sub_cnt  <= '0;
      end else if (acq) begin
        div_cnt <= '0;
        sub_cnt <= sub_cnt + 4'd1;
        if (apply) begin
          active_int  <= shadow_int;
          active_frac <= shadow_frac;
          frac_acc    <= '0;
          period      <= {1'b0, shadow_int};
        end else begin
          frac_acc <= frac_sum[3:0];
          period   <= {1'b0, active_int} + {16'd0, frac_sum[4]};
        end
      end else if (state == RUN) begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end
  assign bus.acq_sig   = acq;
  assign bus.baud_sig  = baud;
  assign bus.div_error = div_error;
  assign bus.running   = (state == RUN);
endmodule

// File: tb/tb_baud_generator.sv
// tb_baud_generator: directed checks of divide ratios, deferred loads, enable toggling and async reset
module tb_baud_generator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   aq[$];
  int   bq[$];
  int   e0, e1;
  logic hit;
  baud_generator_if bus();
  baud_generator dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.acq_sig) aq.push_back(cyc);
    if (bus.baud_sig) begin
      bq.push_back(cyc);
      check("baud_with_acq", {31'd0, bus.acq_sig}, 1);
    end
  end
  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int iv(int k);
    return (aq.size() > k) ? aq[k] - aq[k-1] : -1;
  endfunction
  task automatic wait_acq(int n);
    int t = 0;
    while (aq.size() < n && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    if (aq.size() < n) check("acq_timeout", aq.size(), n);
  endtask
  task automatic wait_baud(int n);
    int t = 0;
    while (bq.size() < n && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    if (bq.size() < n) check("baud_timeout", bq.size(), n);
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic start_run(int di, int df, output int e);
    step(1);
    bus.enable = 1'b0;
    step(2);
    aq.delete();
    bq.delete();
    bus.div_int  = di[15:0];
    bus.div_frac = df[3:0];
    bus.load     = 1'b1;
    bus.enable   = 1'b1;
    e = cyc;
    step(1);
    bus.load = 1'b0;
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.load = 1'b0;
    bus.div_int = 16'd0;
    bus.div_frac = 4'd0;
    #3;
    check("rst_acq", bus.acq_sig, 0);
    check("rst_baud", bus.baud_sig, 0);
    check("rst_err", bus.div_error, 0);
    check("rst_run", bus.running, 0);
    @(negedge clk) rst_n = 1'b1;
    // integer divide by 4
    step(1);
    bus.div_int = 16'd4;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check("int_err", bus.div_error, 0);
    check("int_idle", bus.running, 0);
    bus.enable = 1'b1;
    e0 = cyc;
    wait_acq(33);
    check("int_first_acq", aq[0] - e0, 4);
    check("int_iv1", iv(1), 4);
    check("int_iv5", iv(5), 4);
    check("int_iv16", iv(16), 4);
    check("int_baud0", bq[0] - e0, 64);
    check("int_baud_sp", bq[1] - bq[0], 64);
    check("int_running", bus.running, 1);
    // fractional 4 + 8/16
    start_run(4, 8, e0);
    wait_acq(33);
    check("frac_first_acq", aq[0] - e0, 4);
    check("frac_iv1", iv(1), 4);
    check("frac_iv2", iv(2), 5);
    check("frac_iv3", iv(3), 4);
    check("frac_iv4", iv(4), 5);
    check("frac_baud0", bq[0] - e0, 71);
    check("frac_baud_sp", bq[1] - bq[0], 72);
    // deferred load mid-bit
    start_run(4, 0, e0);
    step(29);
    bus.div_int = 16'd8;
    bus.div_frac = 4'd0;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    wait_acq(19);
    check("dfr_iv15", iv(15), 4);
    check("dfr_iv16", iv(16), 8);
    check("dfr_iv17", iv(17), 8);
    check("dfr_acq17", aq[16] - e0, 72);
    wait_baud(2);
    check("dfr_baud0", bq[0] - e0, 64);
    check("dfr_baud1", bq[1] - e0, 192);
    // invalid load then valid load
    start_run(4, 0, e0);
    step(9);
    bus.div_int = 16'd1;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check("inv_err_set", bus.div_error, 1);
    wait_baud(1);
    while (cyc < e0 + 70) step(1);
    bus.div_int = 16'd6;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check("inv_err_clr", bus.div_error, 0);
    wait_acq(34);
    check("inv_iv16", iv(16), 4);
    check("inv_iv31", iv(31), 4);
    check("inv_iv32", iv(32), 6);
    check("inv_iv33", iv(33), 6);
    // enable toggle while DivCnt == 2
    start_run(4, 0, e0);
    step(2);
    bus.enable = 1'b0;
    check("tog_run_last", bus.running, 1);
    step(1);
    check("tog_run_off", bus.running, 0);
    step(20);
    check("tog_no_acq", aq.size(), 0);
    bus.enable = 1'b1;
    e1 = cyc;
    wait_baud(1);
    check("tog_first_acq", aq[0] - e1, 4);
    check("tog_baud0", bq[0] - e1, 64);
    // async reset while a strobe is high
    bus.div_int = 16'd0;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check("rr_err_set", bus.div_error, 1);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = bus.acq_sig;
    end
    check("rr_acq_seen", {31'd0, hit}, 1);
    #1 rst_n = 1'b0;
    bus.enable = 1'b0;
    #1;
    check("rr_acq", bus.acq_sig, 0);
    check("rr_run", bus.running, 0);
    check("rr_err", bus.div_error, 0);
    @(negedge clk) rst_n = 1'b1;
    aq.delete();
    bq.delete();
    step(20);
    check("rr_idle_acq", aq.size(), 0);
    check("rr_idle_run", bus.running, 0);
    bus.enable = 1'b1;
    e0 = cyc;
    wait_baud(1);
    check("rr_first_acq", aq[0] - e0, 27);
    check("rr_iv1", iv(1), 27);
    check("rr_iv7", iv(7), 27);
    check("rr_iv8", iv(8), 28);
    check("rr_baud0", bq[0] - e0, 433);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
